// File: rtl/wbm_request_arbiter_if.sv
// Bundle of requester-side and bus-master-side signals for wbm_request_arbiter.
// The master modport is the arbiter's own view. The slave modport is the view
// of the surrounding logic, which is the requesters plus the bus master engine.
interface wbm_request_arbiter_if #(
  parameter int NUM_REQ       = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_PAYLOAD   = 8,
  parameter int LEN_N         = 3
) ();
  localparam int PW = MAX_PAYLOAD * DATA_WIDTH;

  // requester side
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_write;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_REQ*PW-1:0]            req_payload;
  logic [NUM_REQ*LEN_N-1:0]         req_length;
  logic [NUM_REQ-1:0]               req_ack;
  logic [NUM_REQ-1:0]               req_done;
  logic                             req_timeout;
  logic [PW-1:0]                    req_rdata;

  // bus master side
  logic [ADDRESS_WIDTH-1:0]         m_transfer_address;
  logic [PW-1:0]                    m_payload_in;
  logic [LEN_N-1:0]                 m_payload_length;
  logic                             m_start_read;
  logic                             m_start_write;
  logic                             m_read_busy;
  logic                             m_write_busy;
  logic                             m_completed;
  logic                             m_timeout;
  logic [PW-1:0]                    m_payload_out;

  modport master (
    input  req_valid, req_write, req_address, req_payload, req_length,
    output req_ack, req_done, req_timeout, req_rdata,
    output m_transfer_address, m_payload_in, m_payload_length,
    output m_start_read, m_start_write,
    input  m_read_busy, m_write_busy, m_completed, m_timeout, m_payload_out
  );

  modport slave (
    output req_valid, req_write, req_address, req_payload, req_length,
    input  req_ack, req_done, req_timeout, req_rdata,
    input  m_transfer_address, m_payload_in, m_payload_length,
    input  m_start_read, m_start_write,
    output m_read_busy, m_write_busy, m_completed, m_timeout, m_payload_out
  );
endinterface

// File: rtl/wbm_request_arbiter.sv
// Round-robin arbiter that shares one bus master engine between NUM_REQ requesters.
// The arbiter grants one requester and latches its command. It issues the
// command to the master, waits for the master to finish, and returns the
// response to the same requester.
// Optional feature: define WBM_ARB_RETRY_EN to retry a timed-out transfer once
// before reporting the failure.
module wbm_request_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_PAYLOAD   = 8,
  parameter int LEN_N         = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wbm_request_arbiter_if.master bus
);
  localparam int PW    = MAX_PAYLOAD * DATA_WIDTH;
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    GRANT     = 5'b00010,
    ISSUE     = 5'b00100,
    WAIT_DONE = 5'b01000,
    RESP      = 5'b10000
  } state_t;

  state_t                   state_reg;
  logic [SEL_W-1:0]         sel_reg;
  logic [SEL_W-1:0]         last_grant_reg;
  logic                     write_reg;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [PW-1:0]            wdata_reg;
  logic [LEN_N-1:0]         len_reg;
  logic                     start_rd_reg;
  logic                     start_wr_reg;
  logic [NUM_REQ-1:0]       ack_reg;
  logic [NUM_REQ-1:0]       done_reg;
  logic                     timeout_reg;
  logic [PW-1:0]            rdata_reg;
`ifdef WBM_ARB_RETRY_EN
  logic                     retry_reg;
`endif

  // Per-requester views of the packed command fields
  logic [ADDRESS_WIDTH-1:0] addr_arr    [NUM_REQ];
  logic [PW-1:0]            payload_arr [NUM_REQ];
  logic [LEN_N-1:0]         len_arr     [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]    = bus.req_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign payload_arr[gi] = bus.req_payload[gi*PW +: PW];
    assign len_arr[gi]     = bus.req_length[gi*LEN_N +: LEN_N];
  end

  // Round-robin pick: the nearest valid requester above last_grant, with wrap.
  // The scan runs from farthest to nearest, so the nearest valid requester is
  // the last one written and wins.
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] cand_idx;
  logic             pick_found;
  always_comb begin
    pick_idx   = '0;
    cand_idx   = '0;
    pick_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_idx = SEL_W'((int'(last_grant_reg) + k) % NUM_REQ);
      if (bus.req_valid[cand_idx]) begin
        pick_idx   = cand_idx;
        pick_found = 1'b1;
      end
    end
  end

  // Busy flag that belongs to the transfer in flight, and the retry decision
  logic cur_busy;
  logic retry_now;
  always_comb begin
    cur_busy = write_reg ? bus.m_write_busy : bus.m_read_busy;
`ifdef WBM_ARB_RETRY_EN
    retry_now = bus.m_timeout && !retry_reg;
`else
    retry_now = 1'b0;
`endif
  end

  // Control FSM. All bus-facing outputs are registered here.
  // m_completed is not stored: busy dropping marks the end of a transfer, and
  // m_timeout is the only failure indication that is passed back.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      sel_reg        <= '0;
      last_grant_reg <= SEL_W'(NUM_REQ - 1);
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      len_reg        <= '0;
      start_rd_reg   <= 1'b0;
      start_wr_reg   <= 1'b0;
      ack_reg        <= '0;
      done_reg       <= '0;
      timeout_reg    <= 1'b0;
      rdata_reg      <= '0;
`ifdef WBM_ARB_RETRY_EN
      retry_reg      <= 1'b0;
`endif
    end else begin
      ack_reg  <= '0;
      done_reg <= '0;
      unique case (state_reg)
        IDLE: begin
          if (pick_found) begin
            sel_reg   <= pick_idx;
            ack_reg   <= NUM_REQ'(1) << pick_idx;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          write_reg    <= bus.req_write[sel_reg];
          addr_reg     <= addr_arr[sel_reg];
          wdata_reg    <= payload_arr[sel_reg];
          len_reg      <= len_arr[sel_reg];
          start_rd_reg <= !bus.req_write[sel_reg];
          start_wr_reg <= bus.req_write[sel_reg];
`ifdef WBM_ARB_RETRY_EN
          retry_reg    <= 1'b0;
`endif
          state_reg    <= ISSUE;
        end
        ISSUE: begin
          if (cur_busy) begin
            start_rd_reg <= 1'b0;
            start_wr_reg <= 1'b0;
            state_reg    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!cur_busy) begin
            if (retry_now) begin
`ifdef WBM_ARB_RETRY_EN
              retry_reg    <= 1'b1;
`endif
              start_rd_reg <= !write_reg;
              start_wr_reg <= write_reg;
              state_reg    <= ISSUE;
            end else begin
              done_reg    <= NUM_REQ'(1) << sel_reg;
              timeout_reg <= bus.m_timeout;
              rdata_reg   <= write_reg ? '0 : bus.m_payload_out;
              state_reg   <= RESP;
            end
          end
        end
        RESP: begin
          last_grant_reg <= sel_reg;
          timeout_reg    <= 1'b0;
          rdata_reg      <= '0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ack            = ack_reg;
  assign bus.req_done           = done_reg;
  assign bus.req_timeout        = timeout_reg;
  assign bus.req_rdata          = rdata_reg;
  assign bus.m_transfer_address = addr_reg;
  assign bus.m_payload_in       = wdata_reg;
  assign bus.m_payload_length   = len_reg;
  assign bus.m_start_read       = start_rd_reg;
  assign bus.m_start_write      = start_wr_reg;
endmodule
